// File: rtl/m_store_buffer_pkg.sv
// Shared definitions for the M-stage store buffer: store op codes, byte-enable
// constants, the buffered entry record and the lane-merge helper.
`timescale 1ns/1ps
package m_store_buffer_pkg;

  localparam logic [1:0] ST_SW   = 2'b00;
  localparam logic [1:0] ST_SH   = 2'b01;
  localparam logic [1:0] ST_SB   = 2'b10;
  localparam logic [1:0] ST_NONE = 2'b11;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_HI   = 4'b1100;

  // Word-address field is sized for the widest supported AW; narrower builds zero-extend.
  localparam int SB_MAX_AW = 64;
  localparam int SB_WORD_W = SB_MAX_AW - 2;

  typedef struct packed {
    logic [SB_WORD_W-1:0] word;
    logic [31:0]          wdata;
    logic [3:0]           byteen;
  } sb_entry_t;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_d,
                                              input logic [31:0] new_d,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_d[8*b +: 8] : old_d[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/m_store_buffer_store_align.sv
// Combinational store aligner: replicates rt into byte lanes, builds byte
// enables and flags misaligned SW/SH.
`timescale 1ns/1ps
module store_align
  import m_store_buffer_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  byteen_o,
  output logic        misaligned_o
);

  always_comb begin
    wdata_o      = '0;
    byteen_o     = '0;
    misaligned_o = 1'b0;
    case (op_i)
      ST_SW: begin
        wdata_o      = data_i;
        byteen_o     = BE_WORD;
        misaligned_o = (addr_i != 2'b00);
      end
      ST_SH: begin
        wdata_o      = {2{data_i[15:0]}};
        byteen_o     = addr_i[1] ? BE_HI : BE_LO;
        misaligned_o = addr_i[0];
      end
      ST_SB: begin
        wdata_o  = {4{data_i[7:0]}};
        byteen_o = 4'b0001 << addr_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/m_store_buffer.sv
// Store buffer between M stage and data memory: aligns, filters misaligned stores,
// queues entries and drains them in order. STORE_MERGE_EN enables tail merging.
`timescale 1ns/1ps
module m_store_buffer
  import m_store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          st_valid,
  input  logic [1:0]    st_op,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  output logic          st_ready,
  output logic          st_ades,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_byteen,
  input  logic          mem_ack,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_hit,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  sb_entry_t    ent_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic          ades_q, ades_d;

  logic [31:0]   al_wdata;
  logic [3:0]    al_be;
  logic          al_mis;
  sb_entry_t     new_ent, head_ent, wr_ent;
  logic [PW-1:0] wr_idx;
  logic          full, merge_possible, accept, push, pop, do_merge, wr_en;
  logic [DEPTH-1:0] ent_valid;
  logic          unused_ld_lo;

  store_align u_align (
    .op_i         (st_op),
    .addr_i       (st_addr[1:0]),
    .data_i       (st_data),
    .wdata_o      (al_wdata),
    .byteen_o     (al_be),
    .misaligned_o (al_mis)
  );

  assign new_ent = '{word: SB_WORD_W'(st_addr[AW-1:2]), wdata: al_wdata, byteen: al_be};
  assign full    = (count_q == (PW+1)'(DEPTH));

`ifdef STORE_MERGE_EN
  logic [PW-1:0] last_idx;
  assign last_idx = tail_q - 1'b1;
  // count>=2 keeps the merge target away from the entry currently presented to memory.
  assign merge_possible = (count_q >= (PW+1)'(2)) && (st_op != ST_NONE) && !al_mis &&
                          (ent_q[last_idx].word == new_ent.word);
`else
  assign merge_possible = 1'b0;
`endif

  // Upstream: a store transfers when st_valid && st_ready && st_op!=ST_NONE at a rising edge.
  // Downstream: head transfers when mem_req && mem_ack at a rising edge; mem_* hold while waiting.
  assign st_ready = !full || merge_possible;
  assign accept   = st_valid && st_ready && (st_op != ST_NONE);
  assign do_merge = accept && merge_possible;
  assign push     = accept && !al_mis && !merge_possible;
  assign mem_req  = (count_q != '0);
  assign pop      = mem_req && mem_ack;
  assign ades_d   = accept && al_mis;

  always_comb begin
    wr_en  = push || do_merge;
    wr_idx = tail_q;
    wr_ent = new_ent;
`ifdef STORE_MERGE_EN
    if (do_merge) begin
      wr_idx        = last_idx;
      wr_ent        = ent_q[last_idx];
      wr_ent.wdata  = merge_lanes(ent_q[last_idx].wdata, al_wdata, al_be);
      wr_ent.byteen = ent_q[last_idx].byteen | al_be;
    end
`endif
  end

  assign head_d  = head_q + PW'(pop);
  assign tail_d  = tail_q + PW'(push);
  assign count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ades_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ades_q  <= ades_d;
      if (wr_en) ent_q[wr_idx] <= wr_ent;
    end
  end

  assign head_ent   = ent_q[head_q];
  assign st_ades    = ades_q;
  assign mem_addr   = mem_req ? AW'({head_ent.word, 2'b00}) : '0;
  assign mem_wdata  = mem_req ? head_ent.wdata : '0;
  assign mem_byteen = mem_req ? head_ent.byteen : '0;
  assign empty      = (count_q == '0);

  // An entry is live when its distance from the head is below the count.
  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = ({1'b0, PW'(i) - head_q} < count_q);
      if (ent_valid[i] && (ent_q[i].word == SB_WORD_W'(ld_addr[AW-1:2]))) ld_hit = 1'b1;
    end
  end

  assign unused_ld_lo = ^ld_addr[1:0];

endmodule

// File: tb/tb_m_store_buffer.sv
// Self-checking bench for m_store_buffer: directed scenarios plus randomized
// traffic against a queue-based reference model (honours STORE_MERGE_EN).
`timescale 1ns/1ps
module tb_m_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int EW    = 30 + 32 + 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          st_valid;
  logic [1:0]    st_op;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic          st_ready, st_ades;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_byteen;
  logic          mem_ack;
  logic [AW-1:0] ld_addr;
  logic          ld_hit, empty;

  always #5 clk = ~clk;

  m_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .st_valid(st_valid), .st_op(st_op), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready), .st_ades(st_ades),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byteen(mem_byteen),
    .mem_ack(mem_ack), .ld_addr(ld_addr), .ld_hit(ld_hit), .empty(empty)
  );

  // Reference model: each entry is {word address, wdata, byteen}, head at index 0.
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  logic          exp_ready, exp_req, exp_hit, exp_empty, exp_ades;
  logic [AW-1:0] exp_addr;
  logic [31:0]   exp_wdata;
  logic [3:0]    exp_be;
  logic          obs_ready, obs_req, obs_hit, obs_empty;
  logic [AW-1:0] obs_addr;
  logic [31:0]   obs_wdata;
  logic [3:0]    obs_be;

  function automatic void ref_align(input logic [1:0] op, input logic [31:0] addr,
                                    input logic [31:0] data, output logic [31:0] wd,
                                    output logic [3:0] be, output logic mis);
    wd = '0; be = '0; mis = 1'b0;
    case (op)
      2'd0: begin wd = data; be = 4'hF; mis = (addr % 4) != 0; end
      2'd1: begin wd = {data[15:0], data[15:0]}; be = ((addr % 4) >= 2) ? 4'hC : 4'h3; mis = (addr % 2) != 0; end
      2'd2: begin wd = {4{data[7:0]}}; be = 4'(1 << (addr % 4)); end
      default: ;
    endcase
  endfunction

  task automatic set_idle();
    st_valid = 1'b0; st_op = 2'b11; st_addr = '0; st_data = '0; mem_ack = 1'b0; ld_addr = '0;
  endtask

  task automatic set_store(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
    st_valid = 1'b1; st_op = op; st_addr = addr; st_data = data;
  endtask

  // Called one time unit after a rising edge: samples the DUT before the next edge,
  // predicts the same outputs from the model, then advances both across the edge.
  task automatic drive_cycle();
    logic [31:0] wd;
    logic [3:0]  be;
    logic        mis, mg, acc, pop;
    logic [EW-1:0] e;
    logic [29:0] sw;
    #1;
    ref_align(st_op, st_addr, st_data, wd, be, mis);
    sw        = st_addr[31:2];
    exp_req   = exp_q.size() != 0;
    exp_empty = !exp_req;
    exp_addr  = '0; exp_wdata = '0; exp_be = '0;
    if (exp_req) begin
      exp_addr  = {exp_q[0][EW-1:36], 2'b00};
      exp_wdata = exp_q[0][35:4];
      exp_be    = exp_q[0][3:0];
    end
    exp_hit = 1'b0;
    foreach (exp_q[i]) if (exp_q[i][EW-1:36] == ld_addr[31:2]) exp_hit = 1'b1;
    mg = 1'b0;
`ifdef STORE_MERGE_EN
    if (exp_q.size() >= 2 && st_op != 2'b11 && !mis && exp_q[exp_q.size()-1][EW-1:36] == sw) mg = 1'b1;
`endif
    exp_ready = (exp_q.size() < DEPTH) || mg;
    obs_ready = st_ready; obs_req = mem_req; obs_addr = mem_addr; obs_wdata = mem_wdata;
    obs_be = mem_byteen; obs_hit = ld_hit; obs_empty = empty;
    acc = st_valid && exp_ready && (st_op != 2'b11);
    pop = exp_req && mem_ack;
    @(posedge clk);
    if (pop) void'(exp_q.pop_front());
    if (acc && !mis) begin
      if (mg) begin
        e = exp_q[exp_q.size()-1];
        for (int b = 0; b < 4; b++) if (be[b]) e[4+8*b +: 8] = wd[8*b +: 8];
        e[3:0] = e[3:0] | be;
        exp_q[exp_q.size()-1] = e;
      end else begin
        exp_q.push_back({sw, wd, be});
      end
    end
    exp_ades = acc && mis;
    #1;
  endtask

  task automatic drain();
    set_idle();
    mem_ack = 1'b1;
    for (int k = 0; k < 3 * DEPTH && exp_q.size() != 0; k++) drive_cycle();
    mem_ack = 1'b0;
    drive_cycle();
  endtask

  task automatic test_reset();
    set_idle();
    reset_n = 1'b0;
    #12;
    n_checks++; if (st_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_st_ready got=%b want=1", st_ready); end
    n_checks++; if (st_ades !== 1'b0)   begin n_fail++; $display("FAIL reset_st_ades got=%b want=0", st_ades); end
    n_checks++; if (mem_req !== 1'b0)   begin n_fail++; $display("FAIL reset_mem_req got=%b want=0", mem_req); end
    n_checks++; if (mem_addr !== '0)    begin n_fail++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
    n_checks++; if (mem_wdata !== '0)   begin n_fail++; $display("FAIL reset_mem_wdata got=%h want=0", mem_wdata); end
    n_checks++; if (mem_byteen !== '0)  begin n_fail++; $display("FAIL reset_mem_byteen got=%b want=0", mem_byteen); end
    n_checks++; if (ld_hit !== 1'b0)    begin n_fail++; $display("FAIL reset_ld_hit got=%b want=0", ld_hit); end
    n_checks++; if (empty !== 1'b1)     begin n_fail++; $display("FAIL reset_empty got=%b want=1", empty); end
    exp_q.delete();
    exp_ades = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sw_basic();
    mem_ack = 1'b1;
    set_store(2'b00, 32'h1000, 32'hDEADBEEF);
    drive_cycle();
    st_valid = 1'b0; st_op = 2'b11;
    drive_cycle();
    n_checks++; if (obs_req !== 1'b1)         begin n_fail++; $display("FAIL sw_req got=%b want=1", obs_req); end
    n_checks++; if (obs_addr !== 32'h1000)    begin n_fail++; $display("FAIL sw_addr got=%h want=00001000", obs_addr); end
    n_checks++; if (obs_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata got=%h want=deadbeef", obs_wdata); end
    n_checks++; if (obs_be !== 4'b1111)       begin n_fail++; $display("FAIL sw_byteen got=%b want=1111", obs_be); end
    n_checks++; if (empty !== 1'b1)           begin n_fail++; $display("FAIL sw_empty_after_pop got=%b want=1", empty); end
    n_checks++; if (mem_req !== 1'b0)         begin n_fail++; $display("FAIL sw_req_after_pop got=%b want=0", mem_req); end
    mem_ack = 1'b0;
  endtask

  task automatic test_sb_sh();
    mem_ack = 1'b0;
    set_store(2'b10, 32'h2003, 32'h000000A5);
    drive_cycle();
    set_store(2'b01, 32'h2002, 32'h00001234);
    drive_cycle();
    set_idle();
    mem_ack = 1'b1;
    drive_cycle();
    n_checks++; if (obs_addr !== 32'h2000)      begin n_fail++; $display("FAIL sb_addr got=%h want=00002000", obs_addr); end
    n_checks++; if (obs_wdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sb_wdata got=%h want=a5a5a5a5", obs_wdata); end
    n_checks++; if (obs_be !== 4'b1000)         begin n_fail++; $display("FAIL sb_byteen got=%b want=1000", obs_be); end
    drive_cycle();
    n_checks++; if (obs_wdata !== 32'h12341234) begin n_fail++; $display("FAIL sh_wdata got=%h want=12341234", obs_wdata); end
    n_checks++; if (obs_be !== 4'b1100)         begin n_fail++; $display("FAIL sh_byteen got=%b want=1100", obs_be); end
    n_checks++; if (empty !== 1'b1)             begin n_fail++; $display("FAIL sh_empty got=%b want=1", empty); end
    mem_ack = 1'b0;
  endtask

  task automatic test_ades();
    set_store(2'b00, 32'h3002, 32'h55AA55AA);
    drive_cycle();
    n_checks++; if (st_ades !== 1'b1) begin n_fail++; $display("FAIL ades_pulse got=%b want=1", st_ades); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL ades_no_enqueue got=%b want=0", mem_req); end
    set_idle();
    drive_cycle();
    n_checks++; if (st_ades !== 1'b0) begin n_fail++; $display("FAIL ades_one_cycle got=%b want=0", st_ades); end
    n_checks++; if (empty !== 1'b1)   begin n_fail++; $display("FAIL ades_empty got=%b want=1", empty); end
  endtask

  task automatic test_full_stall();
    logic [31:0] a0, d0;
    logic [3:0]  b0;
    mem_ack = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      set_store(2'b00, 32'h6000 + 32'(4 * k), $urandom);
      drive_cycle();
    end
    set_store(2'b00, 32'h6010, 32'hC0FFEE05);
    drive_cycle();
    a0 = obs_addr; d0 = obs_wdata; b0 = obs_be;
    n_checks++; if (obs_ready !== 1'b0)   begin n_fail++; $display("FAIL full_ready got=%b want=0", obs_ready); end
    n_checks++; if (obs_addr !== 32'h6000) begin n_fail++; $display("FAIL full_head got=%h want=00006000", obs_addr); end
    for (int k = 0; k < 3; k++) begin
      drive_cycle();
      n_checks++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready cyc=%0d got=%b want=0", k, obs_ready); end
      n_checks++; if ({obs_req, obs_addr, obs_wdata, obs_be} !== {1'b1, a0, d0, b0})
        begin n_fail++; $display("FAIL stall_stable cyc=%0d got=%h/%h/%b want=%h/%h/%b", k, obs_addr, obs_wdata, obs_be, a0, d0, b0); end
    end
    mem_ack = 1'b1;
    drive_cycle();
    n_checks++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL ack_cycle_ready got=%b want=0", obs_ready); end
    mem_ack = 1'b0;
    drive_cycle();
    n_checks++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL after_ack_ready got=%b want=1", obs_ready); end
    set_idle();
    mem_ack = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      drive_cycle();
      n_checks++; if (obs_addr !== 32'h6004 + 32'(4 * k))
        begin n_fail++; $display("FAIL full_drain_order k=%0d got=%h want=%h", k, obs_addr, 32'h6004 + 32'(4 * k)); end
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL full_drain_empty got=%b want=1", empty); end
    mem_ack = 1'b0;
  endtask

  task automatic test_ld_hit();
    mem_ack = 1'b0;
    set_store(2'b00, 32'h4000, 32'h11111111);
    drive_cycle();
    set_store(2'b00, 32'h4008, 32'h22222222);
    drive_cycle();
    set_idle();
    ld_addr = 32'h4009;
    drive_cycle();
    n_checks++; if (obs_hit !== 1'b1) begin n_fail++; $display("FAIL ld_hit_4009 got=%b want=1", obs_hit); end
    ld_addr = 32'h4004;
    drive_cycle();
    n_checks++; if (obs_hit !== 1'b0) begin n_fail++; $display("FAIL ld_hit_4004 got=%b want=0", obs_hit); end
    ld_addr = 32'h4008;
    mem_ack = 1'b1;
    drive_cycle();
    drive_cycle();
    n_checks++; if (obs_hit !== 1'b1) begin n_fail++; $display("FAIL ld_hit_popping got=%b want=1", obs_hit); end
    drive_cycle();
    n_checks++; if (obs_hit !== 1'b0) begin n_fail++; $display("FAIL ld_hit_drained got=%b want=0", obs_hit); end
    set_idle();
  endtask

  task automatic test_merge();
    mem_ack = 1'b0;
    set_store(2'b00, 32'h7000, 32'h77777777);
    drive_cycle();
    set_store(2'b10, 32'h5000, 32'h00000011);
    drive_cycle();
    set_store(2'b10, 32'h5001, 32'h00000022);
    drive_cycle();
    set_idle();
    mem_ack = 1'b1;
    drive_cycle();
    drive_cycle();
`ifdef STORE_MERGE_EN
    n_checks++; if (obs_wdata !== 32'h11112211) begin n_fail++; $display("FAIL merge_wdata got=%h want=11112211", obs_wdata); end
    n_checks++; if (obs_be !== 4'b0011)         begin n_fail++; $display("FAIL merge_byteen got=%b want=0011", obs_be); end
    n_checks++; if (empty !== 1'b1)             begin n_fail++; $display("FAIL merge_single_entry got=%b want=1", empty); end
`else
    n_checks++; if (obs_be !== 4'b0001)         begin n_fail++; $display("FAIL nomerge_first_be got=%b want=0001", obs_be); end
    drive_cycle();
    n_checks++; if (obs_wdata !== 32'h22222222) begin n_fail++; $display("FAIL nomerge_second_wdata got=%h want=22222222", obs_wdata); end
    n_checks++; if (obs_be !== 4'b0010)         begin n_fail++; $display("FAIL nomerge_second_be got=%b want=0010", obs_be); end
`endif
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      st_valid = ($urandom_range(0, 9) < 7);
      st_op    = 2'($urandom_range(0, 3));
      st_addr  = 32'h8000 + 32'($urandom_range(0, 15));
      st_data  = $urandom;
      mem_ack  = ($urandom_range(0, 1) == 1);
      ld_addr  = 32'h8000 + 32'($urandom_range(0, 15));
      drive_cycle();
      n_checks++; if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, obs_ready, exp_ready); end
      n_checks++; if (obs_req !== exp_req)     begin n_fail++; $display("FAIL rnd_req c=%0d got=%b want=%b", c, obs_req, exp_req); end
      n_checks++; if ({obs_addr, obs_wdata, obs_be} !== {exp_addr, exp_wdata, exp_be})
        begin n_fail++; $display("FAIL rnd_head c=%0d got=%h/%h/%b want=%h/%h/%b", c, obs_addr, obs_wdata, obs_be, exp_addr, exp_wdata, exp_be); end
      n_checks++; if (obs_hit !== exp_hit)     begin n_fail++; $display("FAIL rnd_ld_hit c=%0d got=%b want=%b", c, obs_hit, exp_hit); end
      n_checks++; if (obs_empty !== exp_empty) begin n_fail++; $display("FAIL rnd_empty c=%0d got=%b want=%b", c, obs_empty, exp_empty); end
      n_checks++; if (st_ades !== exp_ades)    begin n_fail++; $display("FAIL rnd_ades c=%0d got=%b want=%b", c, st_ades, exp_ades); end
    end
    drain();
  endtask

  task automatic test_async_reset();
    mem_ack = 1'b0;
    set_store(2'b00, 32'h9000, 32'hABCD0001);
    drive_cycle();
    set_store(2'b00, 32'h9004, 32'hABCD0002);
    drive_cycle();
    set_idle();
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL arst_pre_req got=%b want=1", mem_req); end
    #3 reset_n = 1'b0;
    #1;
    n_checks++; if (mem_req !== 1'b0)  begin n_fail++; $display("FAIL arst_req got=%b want=0", mem_req); end
    n_checks++; if (empty !== 1'b1)    begin n_fail++; $display("FAIL arst_empty got=%b want=1", empty); end
    n_checks++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready got=%b want=1", st_ready); end
    exp_q.delete();
    exp_ades = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b1;
    drive_cycle();
    n_checks++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL arst_no_replay got=%b want=0", obs_req); end
    mem_ack = 1'b0;
  endtask

  initial begin
    set_idle();
    reset_n = 1'b1;
    exp_ades = 1'b0;
    test_reset();
    test_sw_basic();
    test_sb_sh();
    test_ades();
    test_full_stall();
    test_ld_hit();
    test_merge();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/m_store_buffer.md
Name: m_store_buffer

Overview:
- Store-side counterpart of the W-stage load extender.
- Accepts SW/SH/SB from the M stage, aligns the data into byte lanes, generates byte enables and flags misaligned stores (AdES).
- Holds stores in a small FIFO and drains them to the data-memory/bridge port over a req/ack handshake.
- Reports pending same-word stores so hazard control can stall dependent loads.

Parameters:
- DEPTH, 4: number of buffered stores; power of two, at least 2.
- AW, 32: address width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- st_valid  in  1  M stage presents a store.
- st_op  in  2  store type: 00 SW, 01 SH, 10 SB, 11 none.
- st_addr  in  AW  byte address.
- st_data  in  32  rt value, unaligned.
- st_ready  out  1  buffer can accept a store this cycle.
- st_ades  out  1  registered one-cycle pulse: the store just accepted was misaligned and was dropped.
- mem_req  out  1  head entry is valid and presented.
- mem_addr  out  AW  word-aligned address: addr with bits [1:0] forced to 00.
- mem_wdata  out  32  lane-aligned write data.
- mem_byteen  out  4  byte enables.
- mem_ack  in  1  memory accepts the head this cycle.
- ld_addr  in  AW  address of the load in M/E.
- ld_hit  out  1  a valid entry has the same word address: ld_addr[AW-1:2].
- empty  out  1  no valid entries (used for eret/syscall sync).

Behaviour:
- Reset values: st_ready=1, st_ades=0, mem_req=0, mem_addr=0, mem_wdata=0, mem_byteen=0, ld_hit=0, empty=1.
- Reset is asynchronous. Asserting reset mid-operation clears all entries and pointers immediately. mem_req drops in the same cycle, even while awaiting ack; no partial write is replayed.
- Accept condition: st_valid && st_ready && st_op!=11. st_op==11 is ignored: no state change, no st_ades.
- st_ready = !full. A store offered while full is not taken; upstream stalls and holds its inputs.
- Misalignment rules:
  - SW is misaligned when addr[1:0]!=0.
  - SH is misaligned when addr[0]!=0.
  - SB is never misaligned.
  - A misaligned accepted store is not enqueued. st_ades=1 in the next cycle only.
- Alignment for SW: wdata=data, byteen=1111.
- Alignment for SH: wdata={data[15:0],data[15:0]}. byteen=0011 when addr[1]=0, 1100 when addr[1]=1.
- Alignment for SB: wdata={4{data[7:0]}}, byteen=0001<<addr[1:0].
- Latency: an entry accepted at edge N drives mem_req=1 starting after edge N, i.e. in the following cycle. There is no combinational bypass from st_* to mem_*.
- Handshake:
  - mem_req/mem_addr/mem_wdata/mem_byteen are driven from the head entry. They stay stable while mem_req=1 && mem_ack=0.
  - mem_req && mem_ack at edge N pops the head; the next entry, if any, is presented after edge N.
  - mem_ack while mem_req=0 is ignored.
- Simultaneous push and pop: both take effect and the count is unchanged. When full, st_ready is still 0 in that cycle, so no push occurs.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. A separate count, 0..DEPTH, distinguishes full from empty.
- ld_hit is combinational over all valid entries. The entry being popped in the current cycle still counts as a hit.
- Ordering: strict FIFO. Memory observes stores in program order.

Optional Feature:
- Macro: STORE_MERGE_EN.
- Defined:
  - An aligned store is merged into the tail entry when count>=2 and its word address equals the tail's word address. count>=2 guarantees the tail is not the presented head.
  - Merge rules: byteen_tail |= byteen_new; lanes enabled by byteen_new are overwritten with the new data.
  - A merge is permitted when full: st_ready = !full || merge_possible.
  - No count change on a merge.
- Undefined: every aligned store allocates a new entry. Ready and count behaviour as above.

Decomposition:
- Shared package holds:
  - store op codes: ST_SW=2'b00, ST_SH=2'b01, ST_SB=2'b10, ST_NONE=2'b11;
  - byte-enable constants BE_WORD=4'b1111, BE_LO=4'b0011, BE_HI=4'b1100;
  - entry record: addr word, wdata, byteen.
- One sub-module, store_align: combinational (op, addr, data) -> (wdata, byteen, misaligned). It is reused by the hazard and bridge tests.

Test Plan:
- Reset then SW addr 0x1000 data 0xDEADBEEF, ack held 1 -> next cycle mem_req=1, mem_addr=0x1000, wdata=0xDEADBEEF, byteen=1111; entry popped; empty=1 one cycle later.
- SB addr 0x2003 data 0x000000A5 -> wdata=0xA5A5A5A5, byteen=1000. SH addr 0x2002 data 0x1234 -> wdata=0x12341234, byteen=1100.
- SW addr 0x3002 -> st_ades=1 for exactly one cycle; nothing enqueued; mem_req stays 0.
- ack held 0, push 4 stores -> st_ready=0, full. Hold ack low 3 cycles -> mem_* stable. Pulse ack -> st_ready=1; the 5th store is accepted in the same cycle.
- Entries at 0x4000 and 0x4008 pending, ld_addr=0x4009 -> ld_hit=1. ld_addr=0x4004 -> ld_hit=0.
- Assert reset_n=0 while mem_req=1 -> mem_req=0 and empty=1 in the same cycle, without waiting for a clock. With STORE_MERGE_EN: SB 0x5000 then SB 0x5001 into tail, count>=2 -> one entry with byteen=0011.
